interface_fft_stream: RTL and testbench
=======================================

// Module: interface_fft_stream
// PURPOSE
//   512-point complex FFT front end between the audio codec and downstream spectral logic.
//   Captures one real 18-bit codec sample per clock, runs an iterative in-place radix-2 DIT FFT,
//   then streams the 512 bins out in natural order with an address and a valid strobe.
//   Free-running: LOAD -> COMPUTE -> UNLOAD -> LOAD, forever after reset.
// PARAMETERS
//   LOG_N   9   log2 of FFT size (N = 512); counters, memory and twiddle ROM sized from it
//   DW      18  sample/bin width, signed two's complement
//   TW      18  twiddle width, signed Q2.16 (+1.0 = 65536)
// PORTS
//   clk                input   1   rising-edge clock
//   reset              input   1   synchronous, active-low
//   sample_from_codec  input   18  signed real input sample, consumed every LOAD cycle
//   data_real_out      output  18  signed real part of bin counter_addr
//   data_imag_out      output  18  signed imaginary part of bin counter_addr
//   counter_addr       output  9   bin index of current output word (0..511)
//   read_valid         output  1   high while data_*_out/counter_addr carry a valid bin
//   done               output  1   one-cycle pulse with the last bin (counter_addr==511)
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=LOAD, sample index 0, all outputs 0; memory contents don't-care.
// - LOAD, 512 cycles: each posedge writes {re=sample_from_codec, im=0} to bit-reversed(index);
//   index 0..511, then -> COMPUTE. The first sample is the one present on the first posedge with reset==1.
// - COMPUTE, exactly 9*256 = 2304 cycles: one butterfly per clock. The working memory has
//   two asynchronous read ports; both results are written on the same edge.
//   Stage s (0..8), butterfly j (0..255): span h = 2^s, group = j>>s, pos = j mod h,
//   a = group*2h + pos, b = a + h, twiddle index k = pos << (8-s).
// - Twiddle ROM: 256 entries, W[k] = round(65536*cos(2*pi*k/512)) - j*round(65536*sin(2*pi*k/512)),
//   constant-filled at elaboration.
// - Butterfly arithmetic:
//     T = W*B, full 36-bit complex products, arithmetic >>>16 (truncate);
//     A' = (A+T)>>>1, B' = (A-T)>>>1, using 19-bit intermediates, results written back as 18 bits.
//   Per-stage halving gives output = DFT/512; there is no overflow for any 18-bit input.
// - Ignored inputs: samples arriving during COMPUTE and UNLOAD are discarded; there is no input buffering.
// - UNLOAD, 512 cycles: outputs are registered. read_valid=1 and counter_addr=0..511 ascending,
//   one per clock; data_*_out holds bin[counter_addr] in the same cycle.
//   done=1 only in the cycle with counter_addr==511. Then -> LOAD, index 0, and a new frame begins.
// - Outside UNLOAD: read_valid=0, done=0; data_*_out and counter_addr hold their last values.
// - Frame period: 512 + 2304 + 512 = 3328 cycles. First read_valid is in cycle 2816 after the
//   first post-reset edge (cycle 0 = first LOAD write).
// - Reset mid-operation (any state): abort immediately to the reset state; a partially output
//   frame is not completed.
// - Bit-reversal wrap: index 511 -> address 511; index 1 -> address 256.
// TESTING
// - Impulse: sample[0]=131071, others 0 -> every bin re within 255+-9, im within 0+-9;
//   done pulses once per frame.
// - DC: all samples 512 -> bin0 re=512 (+-9), im~0; all other bins |re|,|im| <= 9.
// - Cosine at bin 8, amplitude 65536 -> bins 8 and 504 re ~32768 (+-64), im ~0;
//   all other bins magnitude < 64.
// - Sine at bin 32, amplitude 65536 -> bin 32 im ~ -32768, bin 480 im ~ +32768 (+-64);
//   re ~0 in both bins.
// - Timing: read_valid rises exactly 2816 cycles after reset release, stays high 512 cycles with
//   counter_addr 0..511 contiguous; the next frame's first valid comes 3328 cycles after the first.
// - Reset asserted mid-UNLOAD (counter_addr==100) -> next edge read_valid=0, done=0, outputs=0;
//   after release, full timing above repeats.

Source files
------------

// File: rtl/interface_fft_stream_if.sv
// Stream bundle between the codec-side FFT front end and the downstream spectral consumer.
// The master side accepts codec samples and presents bins; the slave side is its counterpart.
interface interface_fft_stream_if #(
  parameter int LOG_N = 9,
  parameter int DW    = 18
);
  logic signed [DW-1:0]    sample_from_codec;
  logic signed [DW-1:0]    data_real_out;
  logic signed [DW-1:0]    data_imag_out;
  logic        [LOG_N-1:0] counter_addr;
  logic                    read_valid;
  logic                    done;

  modport master (
    input  sample_from_codec,
    output data_real_out, data_imag_out, counter_addr, read_valid, done
  );

  modport slave (
    output sample_from_codec,
    input  data_real_out, data_imag_out, counter_addr, read_valid, done
  );
endinterface

// File: rtl/interface_fft_stream.sv
// Free-running 512-point radix-2 DIT FFT: bit-reversed capture, one butterfly per clock in place,
// natural-order unload. Each stage halves its results so the bins come out scaled by 1/N.
module interface_fft_stream #(
  parameter int LOG_N = 9,
  parameter int DW    = 18,
  parameter int TW    = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  interface_fft_stream_if.master bus
);
  localparam int N    = 1 << LOG_N;
  localparam int HALF = N / 2;
  localparam int KW   = LOG_N - 1;
  localparam int SW   = $clog2(LOG_N);
  localparam int FRAC = TW - 2;
  localparam real PI  = 3.14159265358979323846;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t          state;
  logic [LOG_N-1:0] load_idx;
  logic [LOG_N-1:0] unload_idx;
  logic [SW-1:0]    stage;
  logic [KW-1:0]    bfly;

  logic signed [DW-1:0] mem_re [N];
  logic signed [DW-1:0] mem_im [N];
  logic signed [TW-1:0] tw_re  [HALF];
  logic signed [TW-1:0] tw_im  [HALF];

  // Twiddles W[k] = cos - j*sin, rounded half away from zero into Q2.16.
  for (genvar k = 0; k < HALF; k++) begin : g_twiddle
    localparam real ANG = 2.0 * PI * k / N;
    localparam real C_R = real'(1 << FRAC) * $cos(ANG);
    localparam real S_R = real'(1 << FRAC) * $sin(ANG);
    localparam int  C_I = (C_R >= 0.0) ? $rtoi(C_R + 0.5) : $rtoi(C_R - 0.5);
    localparam int  S_I = (S_R >= 0.0) ? $rtoi(S_R + 0.5) : $rtoi(S_R - 0.5);
    assign tw_re[k] = TW'(C_I);
    assign tw_im[k] = TW'(-S_I);
  end

  logic [LOG_N-1:0] j_ext, low_mask, addr_a, addr_b, rd_a, load_addr;
  logic [KW-1:0]    tw_idx;

  // NOTE: every signal driven here gets a value on every path, so no latch can be inferred.
  always_comb begin
    j_ext    = {1'b0, bfly};
    low_mask = LOG_N'((1 << stage) - 1);
    // Butterfly pair: insert a zero at bit 'stage' of j for a, a one for b.
    addr_a   = ((j_ext & ~low_mask) << 1) | (j_ext & low_mask);
    addr_b   = addr_a | (low_mask + 1'b1);
    tw_idx   = KW'((j_ext & low_mask) << (KW - stage));
    rd_a     = (state == S_UNLOAD) ? unload_idx : addr_a;
    for (int i = 0; i < LOG_N; i++) load_addr[i] = load_idx[LOG_N-1-i];
  end

  logic signed [DW-1:0]    a_re, a_im, b_re, b_im;
  logic signed [TW-1:0]    w_re, w_im;
  logic signed [DW+TW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DW+TW:0]   t_re_full, t_im_full;
  logic signed [DW+2:0]    t_re, t_im;
  logic signed [DW+3:0]    s_ar, s_ai, s_br, s_bi;

  assign a_re = mem_re[rd_a];
  assign a_im = mem_im[rd_a];
  assign b_re = mem_re[addr_b];
  assign b_im = mem_im[addr_b];
  assign w_re = tw_re[tw_idx];
  assign w_im = tw_im[tw_idx];

  assign p_rr = (DW+TW)'(b_re) * (DW+TW)'(w_re);
  assign p_ii = (DW+TW)'(b_im) * (DW+TW)'(w_im);
  assign p_ri = (DW+TW)'(b_re) * (DW+TW)'(w_im);
  assign p_ir = (DW+TW)'(b_im) * (DW+TW)'(w_re);

  assign t_re_full = (DW+TW+1)'(p_rr) - (DW+TW+1)'(p_ii);
  assign t_im_full = (DW+TW+1)'(p_ri) + (DW+TW+1)'(p_ir);
  // Dropping the low FRAC bits of a signed value is the arithmetic >>> (truncating).
  assign t_re = t_re_full[DW+TW:FRAC];
  assign t_im = t_im_full[DW+TW:FRAC];

  assign s_ar = (DW+4)'(a_re) + (DW+4)'(t_re);
  assign s_ai = (DW+4)'(a_im) + (DW+4)'(t_im);
  assign s_br = (DW+4)'(a_re) - (DW+4)'(t_re);
  assign s_bi = (DW+4)'(a_im) - (DW+4)'(t_im);

  // NOTE: the working memory is not reset; LOAD rewrites every word before COMPUTE reads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == S_LOAD) begin
        mem_re[load_addr] <= bus.sample_from_codec;
        mem_im[load_addr] <= '0;
      end else if (state == S_COMPUTE) begin
        mem_re[addr_a] <= s_ar[DW:1];
        mem_im[addr_a] <= s_ai[DW:1];
        mem_re[addr_b] <= s_br[DW:1];
        mem_im[addr_b] <= s_bi[DW:1];
      end
    end
  end

  // NOTE: non-blocking assignments so every register updates from its pre-edge value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= S_LOAD;
      load_idx           <= '0;
      unload_idx         <= '0;
      stage              <= '0;
      bfly               <= '0;
      bus.data_real_out  <= '0;
      bus.data_imag_out  <= '0;
      bus.counter_addr   <= '0;
      bus.read_valid     <= 1'b0;
      bus.done           <= 1'b0;
    end else begin
      bus.read_valid <= 1'b0;
      bus.done       <= 1'b0;
      unique case (state)
        S_LOAD: begin
          load_idx <= load_idx + 1'b1;
          if (load_idx == LOG_N'(N - 1)) state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          bfly <= bfly + 1'b1;
          if (bfly == KW'(HALF - 1)) begin
            if (stage == SW'(LOG_N - 1)) begin
              stage <= '0;
              state <= S_UNLOAD;
            end else begin
              stage <= stage + 1'b1;
            end
          end
        end
        S_UNLOAD: begin
          bus.read_valid    <= 1'b1;
          bus.counter_addr  <= unload_idx;
          bus.data_real_out <= a_re;
          bus.data_imag_out <= a_im;
          bus.done          <= (unload_idx == LOG_N'(N - 1));
          unload_idx        <= unload_idx + 1'b1;
          if (unload_idx == LOG_N'(N - 1)) state <= S_LOAD;
        end
        default: state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_interface_fft_stream.sv
// Scoreboard bench: the sample driver queues expected bin ranges as each frame starts,
// a monitor pops and checks them whenever read_valid is high.
module tb_interface_fft_stream;
  localparam int N     = 512;
  localparam int FRAME = 3328;
  localparam int FIRST = 2816;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  interface_fft_stream_if #(.LOG_N(9), .DW(18)) bus ();

  interface_fft_stream dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int re_lo, re_hi, im_lo, im_hi;
    int last;
    int start_edge;
  } exp_t;

  exp_t sb_q[$];
  int   tests    = 0;
  int   fails    = 0;
  int   edge_idx = -1;
  int   phase    = 0;

  // Index of the most recent posedge with reset high; -1 while held in reset.
  always @(posedge clk) begin
    if (!reset) edge_idx <= -1;
    else        edge_idx <= edge_idx + 1;
  end

  task automatic check(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
  endfunction

  // 0 impulse, 1 DC, 2 cosine bin 8, 3 sine bin 32.
  function automatic int kind_of(input int ph, input int frame);
    return (ph == 0 && frame < 4) ? frame : 0;
  endfunction

  function automatic int sample_for(input int kind, input int n);
    real ang;
    case (kind)
      0: return (n == 0) ? 131071 : 0;
      1: return 512;
      2: begin ang = 2.0 * 3.14159265358979 * 8.0 * n / 512.0;  return rnd(65536.0 * $cos(ang)); end
      3: begin ang = 2.0 * 3.14159265358979 * 32.0 * n / 512.0; return rnd(65536.0 * $sin(ang)); end
      default: return 0;
    endcase
  endfunction

  task automatic push_frame(input int kind, input int start_edge);
    exp_t e;
    for (int b = 0; b < N; b++) begin
      e.addr = b; e.last = (b == N - 1); e.start_edge = start_edge;
      e.re_lo = -63; e.re_hi = 63; e.im_lo = -63; e.im_hi = 63;
      case (kind)
        0: begin e.re_lo = 246; e.re_hi = 264; e.im_lo = -9; e.im_hi = 9; end
        1: begin
          e.re_lo = (b == 0) ? 503 : -9; e.re_hi = (b == 0) ? 521 : 9;
          e.im_lo = -9; e.im_hi = 9;
        end
        2: if (b == 8 || b == 504) begin
          e.re_lo = 32704; e.re_hi = 32832; e.im_lo = -64; e.im_hi = 64;
        end
        default: if (b == 32 || b == 480) begin
          e.re_lo = -64; e.re_hi = 64;
          e.im_lo = (b == 32) ? -32832 : 32704; e.im_hi = (b == 32) ? -32704 : 32832;
        end
      endcase
      sb_q.push_back(e);
    end
  endtask

  // Sample driver: drives the sample for the next edge and queues the frame's expectations once.
  initial begin : driver
    int nxt, pos, frame, key, last_key;
    last_key = -1;
    bus.sample_from_codec = '0;
    forever begin
      @(negedge clk);
      nxt   = edge_idx + 1;
      pos   = nxt % FRAME;
      frame = nxt / FRAME;
      if (pos < N) begin
        bus.sample_from_codec = 18'(sample_for(kind_of(phase, frame), pos));
        key = phase * 16 + frame;
        if (pos == 0 && key != last_key && ((phase == 0 && frame <= 4) || (phase == 1 && frame == 0))) begin
          push_frame(kind_of(phase, frame), nxt + FIRST);
          last_key = key;
        end
      end else begin
        bus.sample_from_codec = 18'($urandom);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.read_valid) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bin: got addr %0d, want no output", bus.counter_addr);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("bin%0d_addr", e.addr), int'(bus.counter_addr), e.addr, e.addr);
          check($sformatf("bin%0d_re", e.addr), int'(bus.data_real_out), e.re_lo, e.re_hi);
          check($sformatf("bin%0d_im", e.addr), int'(bus.data_imag_out), e.im_lo, e.im_hi);
          check($sformatf("bin%0d_done", e.addr), int'(bus.done), e.last, e.last);
          if (e.addr == 0) check("first_valid_edge", edge_idx, e.start_edge, e.start_edge);
        end
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, int'(bus.read_valid), 0, 0);
    check({tag, "_done"}, int'(bus.done), 0, 0);
    check({tag, "_re"}, int'(bus.data_real_out), 0, 0);
    check({tag, "_im"}, int'(bus.data_imag_out), 0, 0);
    check({tag, "_addr"}, int'(bus.counter_addr), 0, 0);
  endtask

  initial begin : main
    bit found;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b1;

    // Run impulse, DC, cosine and sine frames, then interrupt frame 4 mid-unload.
    found = 1'b0;
    for (int c = 0; c < 6 * FRAME && !found; c++) begin
      @(negedge clk);
      if (bus.read_valid && bus.counter_addr == 9'd100 && edge_idx > 4 * FRAME) found = 1'b1;
    end
    check("reach_mid_unload", int'(found), 1, 1);

    reset = 1'b0;
    phase = 1;
    #1 sb_q.delete();
    @(negedge clk);
    check_idle_zero("mid_reset");
    reset = 1'b1;

    for (int c = 0; c < 2 * FRAME && sb_q.size() != 0; c++) @(negedge clk);
    check("post_reset_frame_drained", sb_q.size(), 0, 0);
    repeat (2) @(negedge clk);
    check("after_frame_valid", int'(bus.read_valid), 0, 0);
    check("after_frame_done", int'(bus.done), 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
